instr_fetch_unit: RTL and testbench

Upstream stage of the instruction reader. On a start pulse it streams a contiguous block of instruction rows out of the synchronous instruction memory into a small prefetch FIFO. Each row is INSTR_FIFO_WIDTH words. It presents the FIFO head to the reader with a valid/ready handshake. Memory reads are credit-limited, so every returning row always has a free FIFO slot.

---
 rtl/instr_fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: streams a contiguous block of instruction rows from a
// synchronous instruction memory into a small prefetch FIFO and presents the
// FIFO head to the reader.
//
// Handshake (reader side): a row moves on every rising edge where
// fifo_2_reader_vld and reader_2_fifo_rdy are both high. vld never depends on
// rdy, and the head row is held stable while vld is high and rdy is low.
// Memory side: mem_rd_data belongs to the mem_rd_en of the previous cycle.
module instr_fetch_unit #(
    parameter int WORD_LEN         = 32,
    parameter int INSTR_FIFO_WIDTH = 16,
    parameter int MEM_DEPTH        = 1024,
    parameter int FIFO_DEPTH       = 4,
    localparam int AW              = $clog2(MEM_DEPTH)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic [AW-1:0]                                 base_addr,
    input  logic [AW:0]                                   n_rows,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          mem_rd_en,
    output logic [AW-1:0]                                 mem_rd_addr,
    input  logic [0:INSTR_FIFO_WIDTH-1][0:WORD_LEN-1]     mem_rd_data,
    output logic [0:INSTR_FIFO_WIDTH-1][0:WORD_LEN-1]     instr_from_fifo,
    output logic                                          fifo_2_reader_vld,
    input  logic                                          reader_2_fifo_rdy,
    output logic [1:0]                                    dbg_state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef logic [0:INSTR_FIFO_WIDTH-1][0:WORD_LEN-1] row_t;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     issue_left_q, issue_left_d;
    logic [AW:0]     deliver_left_q, deliver_left_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            inflight_q;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, head_q;
    row_t            fifo_q [FIFO_DEPTH];

    logic [CW:0]     occupancy;
    logic            credit_ok;
    logic            rd_issue;
    logic            push;
    logic            pop;

    // Credit check: rows already stored plus the one in flight must leave a slot
    always_comb begin
        occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        credit_ok = occupancy < (CW+1)'(FIFO_DEPTH);
        rd_issue  = (state_q == S_FETCH) && (issue_left_q != '0) && credit_ok;
        push      = inflight_q;
        pop       = (count_q != '0) && reader_2_fifo_rdy;
    end

    // Next-state and block-progress counters
    always_comb begin
        state_d        = state_q;
        rd_ptr_d       = rd_ptr_q;
        issue_left_d   = issue_left_q;
        deliver_left_d = deliver_left_q;
        if (pop) begin
            deliver_left_d = deliver_left_q - (AW+1)'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d        = S_FETCH;
                    rd_ptr_d       = base_addr;
                    issue_left_d   = n_rows;
                    deliver_left_d = n_rows;
                end
            end
            S_FETCH: begin
                if (rd_issue) begin
                    rd_ptr_d     = rd_ptr_q + AW'(1);
                    issue_left_d = issue_left_q - (AW+1)'(1);
                end
                if (issue_left_d == '0) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (deliver_left_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // done is high in the DRAIN cycle that decides the return to IDLE;
        // busy drops in that same cycle.
        busy_d = (state_d == S_FETCH) || ((state_d == S_DRAIN) && (deliver_left_d != '0));
        done_d = (state_d == S_DRAIN) && (deliver_left_d == '0);
    end

    // FIFO occupancy: simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control FSM, read pointer, counters and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            rd_ptr_q       <= '0;
            issue_left_q   <= '0;
            deliver_left_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            inflight_q     <= 1'b0;
            count_q        <= '0;
            wr_ptr_q       <= '0;
            head_q         <= '0;
        end else begin
            state_q        <= state_d;
            rd_ptr_q       <= rd_ptr_d;
            issue_left_q   <= issue_left_d;
            deliver_left_q <= deliver_left_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            inflight_q     <= rd_issue;
            count_q        <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
        end
    end

    // Row storage; returning data is written unconditionally, credits guarantee space
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[wr_ptr_q] <= mem_rd_data;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign mem_rd_en         = rd_issue;
    assign mem_rd_addr       = rd_ptr_q;
    assign instr_from_fifo   = fifo_q[head_q];
    assign fifo_2_reader_vld = (count_q != '0);
    assign dbg_state         = state_q;

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
        !(push && (count_q == CW'(FIFO_DEPTH))));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst)
        !(pop && (count_q == '0)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural instruction memory, randomized
// blocks, and a scoreboard of expected read addresses and delivered rows.
module tb_instr_fetch_unit;

    localparam int WORD_LEN   = 32;
    localparam int IFW        = 16;
    localparam int MEM_DEPTH  = 1024;
    localparam int FIFO_DEPTH = 4;
    localparam int AW         = 10;

    typedef logic [0:IFW-1][0:WORD_LEN-1] row_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   n_rows = '0;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    row_t          mem_rd_data;
    row_t          instr_from_fifo;
    logic          fifo_2_reader_vld;
    logic          rdy = 1'b0;
    logic [1:0]    dbg_state;

    row_t          mem [MEM_DEPTH];
    logic [AW-1:0] exp_addr_q[$];
    row_t          exp_row_q[$];

    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  rd_cnt = 0;
    int  pop_cnt = 0;
    int  done_cnt = 0;
    int  done_cyc = -1;
    int  first_rd = -1;
    int  first_vld = -1;
    int  max_occ = 0;
    bit  stale_inject = 1'b0;

    instr_fetch_unit #(
        .WORD_LEN(WORD_LEN), .INSTR_FIFO_WIDTH(IFW),
        .MEM_DEPTH(MEM_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .n_rows(n_rows),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .instr_from_fifo(instr_from_fifo),
        .fifo_2_reader_vld(fifo_2_reader_vld), .reader_2_fifo_rdy(rdy),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic row_t rand_row();
        row_t r;
        for (int w = 0; w < IFW; w++) r[w] = $urandom;
        return r;
    endfunction

    // synchronous instruction memory; can also scribble on the data bus while idle
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
        else if (stale_inject) mem_rd_data <= rand_row();
    end

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_row(input string name, input row_t act, input row_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input longint act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %0d with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            if (rd_cnt - pop_cnt > max_occ) max_occ = rd_cnt - pop_cnt;
            if (fifo_2_reader_vld && first_vld < 0) first_vld = cyc;
            if (mem_rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
                if (exp_addr_q.size() == 0) fail_now("extra_read_addr", longint'(mem_rd_addr));
                else chk("read_addr", longint'(mem_rd_addr), longint'(exp_addr_q.pop_front()));
            end
            if (fifo_2_reader_vld && rdy) begin
                pop_cnt++;
                if (exp_row_q.size() == 0) fail_now("extra_row_popped", longint'(pop_cnt));
                else chk_row("row_data", instr_from_fifo, exp_row_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", longint'(busy), 0);
                chk("rows_left_at_done", longint'(exp_row_q.size()), 0);
                chk("reads_left_at_done", longint'(exp_addr_q.size()), 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_stats();
        rd_cnt = 0; pop_cnt = 0; first_rd = -1; first_vld = -1;
        done_cyc = -1; max_occ = 0;
    endtask

    task automatic start_block(input int base, input int n, output int t);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = AW'(base);
        n_rows = (AW+1)'(n);
        t = cyc;
        for (int i = 0; i < n; i++) begin
            int a;
            a = (base + i) % MEM_DEPTH;
            exp_addr_q.push_back(AW'(a));
            exp_row_q.push_back(mem[a]);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int k;
        int d0;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk); #1;
            if (rnd) rdy = 1'($urandom_range(0, 1));
            k++;
        end
        chk("done_seen", longint'(done_cnt - d0), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_rd_en"}, longint'(mem_rd_en), 0);
        chk({tag, "_rd_addr"}, longint'(mem_rd_addr), 0);
        chk({tag, "_vld"}, longint'(fifo_2_reader_vld), 0);
        chk({tag, "_state"}, longint'(dbg_state), 0);
        chk_row({tag, "_instr"}, instr_from_fifo, '0);
    endtask

    task automatic run_basic(input int base, input int n);
        int t;
        clear_stats();
        rdy = 1'b1;
        start_block(base, n, t);
        wait_done(200, 1'b0);
        chk("first_read_cycle", longint'(first_rd), longint'(t + 1));
        chk("first_vld_cycle", longint'(first_vld), longint'(t + 3));
        chk("done_cycle", longint'(done_cyc), longint'(t + n + 3));
        chk("reads_issued", longint'(rd_cnt), longint'(n));
        chk("rows_popped", longint'(pop_cnt), longint'(n));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        int k;
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = rand_row();

        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // basic fetch
        run_basic(5, 3);

        // backpressure: reader stalled, FIFO fills to exactly FIFO_DEPTH
        clear_stats();
        rdy = 1'b0;
        start_block(int'($urandom_range(0, MEM_DEPTH - 1)), 10, t);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("stall_reads", longint'(rd_cnt), FIFO_DEPTH);
        chk("stall_vld", longint'(fifo_2_reader_vld), 1);
        chk("stall_busy", longint'(busy), 1);
        chk("stall_max_occ", longint'(max_occ), FIFO_DEPTH);
        @(posedge clk); #1;
        rdy = 1'b1;
        wait_done(200, 1'b0);
        chk("stall_rows_popped", longint'(pop_cnt), 10);
        chk("stall_reads_total", longint'(rd_cnt), 10);

        // address wrap
        run_basic(MEM_DEPTH - 2, 4);

        // empty block
        clear_stats();
        start_block(int'($urandom_range(0, MEM_DEPTH - 1)), 0, t);
        wait_done(50, 1'b0);
        chk("zero_reads", longint'(rd_cnt), 0);
        chk("zero_done_cycle", longint'(done_cyc), longint'(t + 2));
        chk("zero_no_vld", longint'(first_vld), -1);

        // start while busy is ignored
        clear_stats();
        rdy = 1'b1;
        start_block(int'($urandom_range(0, MEM_DEPTH - 1)), 6, t);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = AW'($urandom_range(0, MEM_DEPTH - 1));
        n_rows = (AW+1)'(9);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200, 1'b0);
        repeat (5) @(posedge clk);
        chk("busy_start_reads", longint'(rd_cnt), 6);
        chk("busy_start_pops", longint'(pop_cnt), 6);
        chk("busy_start_done_cycle", longint'(done_cyc), longint'(t + 9));

        // random ready, long block then a few short ones
        for (int r = 0; r < 4; r++) begin
            int n;
            n = (r == 0) ? 64 : int'($urandom_range(1, 40));
            clear_stats();
            start_block(int'($urandom_range(0, MEM_DEPTH - 1)), n, t);
            wait_done(3000, 1'b1);
            chk("rand_rows_popped", longint'(pop_cnt), longint'(n));
            chk("rand_occ_within_depth", longint'(max_occ <= FIFO_DEPTH), 1);
        end

        // reset in the middle of a block
        clear_stats();
        rdy = 1'b1;
        start_block(int'($urandom_range(0, MEM_DEPTH - 1)), 8, t);
        k = 0;
        while (pop_cnt < 2 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        chk("midrun_two_pops", longint'(pop_cnt >= 2), 1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrun_async");
        exp_addr_q.delete();
        exp_row_q.delete();
        stale_inject = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrun_held");
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset_no_vld", longint'(fifo_2_reader_vld), 0);
            chk("post_reset_idle", longint'(busy), 0);
        end
        stale_inject = 1'b0;
        run_basic(5, 3);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
